rel_stream_fifo: RTL

- Reliability-hardened stream FIFO. It sits directly downstream of the TMR spill register and absorbs bursts before the consuming unit.
- Pointers, usage counter and handshake logic are triplicated and majority-voted.
- Payload T is ECC-protected upstream and is stored and forwarded unmodified.
- Shares the spill register's handshake format, so the two blocks chain without glue logic.

---
 rtl/rel_stream_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rel_stream_fifo.sv
// rel_stream_fifo: stream FIFO with triplicated, majority-voted pointers, usage counter and handshake.
// Define REL_STREAM_FIFO_SCRUB_EN to rebuild every state copy from the voted values each cycle.
module rel_stream_fifo #(
    parameter type         T            = logic,
    parameter int unsigned Depth        = 4,
    parameter bit          TmrHandshake = 1'b1,
    parameter int unsigned HsWidth      = TmrHandshake ? 3 : 1,
    parameter int unsigned AddrWidth    = (Depth > 1) ? $clog2(Depth) : 1,
    parameter int unsigned CntWidth     = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [HsWidth-1:0]  valid_i,
    output logic [HsWidth-1:0]  ready_o,
    input  T                    data_i,
    output logic [HsWidth-1:0]  valid_o,
    input  logic [HsWidth-1:0]  ready_i,
    output T                    data_o,
    output logic [CntWidth-1:0] usage_o,
    output logic                fault_o
);
    localparam logic [AddrWidth-1:0] LastPtr = AddrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0]  FullCnt = CntWidth'(Depth);

    logic [AddrWidth-1:0] w_wptr_q [3];
    logic [AddrWidth-1:0] w_rptr_q [3];
    logic [AddrWidth-1:0] w_wptr_v [3];
    logic [AddrWidth-1:0] w_rptr_v [3];
    logic [CntWidth-1:0]  w_usage_q [3];
    logic [CntWidth-1:0]  w_usage_v [3];
    logic [2:0]           w_valid_in, w_ready_in, w_valid_out, w_ready_out, w_push, w_pop, w_part_mm;
    logic [AddrWidth-1:0] w_waddr, w_raddr;
    logic                 w_we, w_addr_mm, w_hs_mm;
    T                     r_mem [Depth];

    function automatic logic [AddrWidth-1:0] maj_ptr(input logic [AddrWidth-1:0] a, b, c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [CntWidth-1:0] maj_cnt(input logic [CntWidth-1:0] a, b, c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic maj_bit(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_part
        localparam int J = (i + 1) % 3;
        localparam int K = (i + 2) % 3;
        logic [AddrWidth-1:0] r_wptr, r_rptr, w_wbase, w_rbase;
        logic [CntWidth-1:0]  r_usage, w_ubase;
        assign w_wptr_q[i]  = r_wptr;
        assign w_rptr_q[i]  = r_rptr;
        assign w_usage_q[i] = r_usage;
        assign w_wptr_v[i]  = maj_ptr(r_wptr, w_wptr_q[J], w_wptr_q[K]);
        assign w_rptr_v[i]  = maj_ptr(r_rptr, w_rptr_q[J], w_rptr_q[K]);
        assign w_usage_v[i] = maj_cnt(r_usage, w_usage_q[J], w_usage_q[K]);
        assign w_part_mm[i] = (r_wptr != w_wptr_q[J]) || (r_wptr != w_wptr_q[K]) ||
                              (r_rptr != w_rptr_q[J]) || (r_rptr != w_rptr_q[K]) ||
                              (r_usage != w_usage_q[J]) || (r_usage != w_usage_q[K]);
        assign w_ready_out[i] = w_usage_v[i] != FullCnt;
        assign w_valid_out[i] = w_usage_v[i] != '0;
        assign w_push[i]      = w_valid_in[i] & w_ready_out[i];
        assign w_pop[i]       = w_valid_out[i] & w_ready_in[i];
`ifdef REL_STREAM_FIFO_SCRUB_EN
        assign w_wbase = w_wptr_v[i];
        assign w_rbase = w_rptr_v[i];
        assign w_ubase = w_usage_v[i];
`else
        assign w_wbase = r_wptr;
        assign w_rbase = r_rptr;
        assign w_ubase = r_usage;
`endif
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_usage <= '0;
            end else begin
                r_wptr  <= w_push[i] ? ((w_wbase == LastPtr) ? '0 : w_wbase + AddrWidth'(1)) : w_wbase;
                r_rptr  <= w_pop[i] ? ((w_rbase == LastPtr) ? '0 : w_rbase + AddrWidth'(1)) : w_rbase;
                r_usage <= (w_push[i] && !w_pop[i]) ? w_ubase + CntWidth'(1) :
                           (w_pop[i] && !w_push[i]) ? w_ubase - CntWidth'(1) : w_ubase;
            end
        end
    end

    if (TmrHandshake) begin : g_tmr_hs
        assign w_valid_in = valid_i;
        assign w_ready_in = ready_i;
        assign valid_o    = w_valid_out;
        assign ready_o    = w_ready_out;
        assign w_hs_mm    = 1'b0;
    end else begin : g_single_hs
        assign w_valid_in = {3{valid_i[0]}};
        assign w_ready_in = {3{ready_i[0]}};
        assign valid_o    = maj_bit(w_valid_out);
        assign ready_o    = maj_bit(w_ready_out);
        assign w_hs_mm    = ((|w_valid_out) & ~(&w_valid_out)) | ((|w_ready_out) & ~(&w_ready_out));
    end

    assign w_we      = maj_bit(w_push);
    assign w_waddr   = maj_ptr(w_wptr_v[0], w_wptr_v[1], w_wptr_v[2]);
    assign w_raddr   = maj_ptr(w_rptr_v[0], w_rptr_v[1], w_rptr_v[2]);
    assign w_addr_mm = (w_wptr_v[0] != w_wptr_v[1]) || (w_wptr_v[0] != w_wptr_v[2]) ||
                       (w_rptr_v[0] != w_rptr_v[1]) || (w_rptr_v[0] != w_rptr_v[2]) ||
                       ((|w_push) && !(&w_push));

    // Storage is cleared on reset so the head entry is never X, even when empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < Depth; n++) r_mem[n] <= '0;
        end else if (w_we) begin
            r_mem[w_waddr] <= data_i;
        end
    end

    assign data_o  = r_mem[w_raddr];
    assign usage_o = maj_cnt(w_usage_q[0], w_usage_q[1], w_usage_q[2]);
    assign fault_o = (|w_part_mm) | w_addr_mm | w_hs_mm;
endmodule
